// File: rtl/rf_wb_if.sv
// rf_wb_if: issue, pipeline writeback, LLU result and register-file write signals of the writeback scheduler
interface rf_wb_if;
    logic        iss_valid_i;
    logic [4:0]  iss_rs1_i;
    logic [4:0]  iss_rs2_i;
    logic        iss_rs1_used_i;
    logic        iss_rs2_used_i;
    logic [4:0]  iss_rd_i;
    logic        iss_long_i;
    logic        iss_stall_o;
    logic        pwb_valid_i;
    logic [4:0]  pwb_addr_i;
    logic [31:0] pwb_data_i;
    logic        llu_valid_i;
    logic        llu_ready_o;
    logic [4:0]  llu_addr_i;
    logic [31:0] llu_data_i;
    logic        rf_wr_en_o;
    logic [4:0]  rf_wr_addr_o;
    logic [31:0] rf_wr_data_o;
    logic [31:0] busy_o;

    modport slave (
        input  iss_valid_i, iss_rs1_i, iss_rs2_i, iss_rs1_used_i, iss_rs2_used_i, iss_rd_i, iss_long_i,
        input  pwb_valid_i, pwb_addr_i, pwb_data_i, llu_valid_i, llu_addr_i, llu_data_i,
        output iss_stall_o, llu_ready_o, rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o, busy_o
    );

    modport master (
        output iss_valid_i, iss_rs1_i, iss_rs2_i, iss_rs1_used_i, iss_rs2_used_i, iss_rd_i, iss_long_i,
        output pwb_valid_i, pwb_addr_i, pwb_data_i, llu_valid_i, llu_addr_i, llu_data_i,
        input  iss_stall_o, llu_ready_o, rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o, busy_o
    );
endinterface

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: shares the RF write port between pipeline writeback and buffered LLU results, and stalls issue on hazards
module rf_wb_scheduler #(
    parameter int FIFO_DEPTH      = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input logic   clk,
    input logic   rst_n,
    rf_wb_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);
    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] SAT     = SW'(STARVE_LIMIT);

    logic [4:0]    fifo_addr [FIFO_DEPTH];
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [OW-1:0] outstanding;
    logic [SW-1:0] starve;
    logic [31:0]   busy;
    logic [4:0]    last_addr, head_addr;
    logic [31:0]   last_data, head_data;
    logic          empty, push, pop, accept_long;

    assign empty          = count == '0;
    assign bus.llu_ready_o = count != FULL;
    assign push           = bus.llu_valid_i && bus.llu_ready_o;
    assign pop            = !bus.pwb_valid_i && !empty;
    assign head_addr      = fifo_addr[rd_ptr];
    assign head_data      = fifo_data[rd_ptr];
    assign bus.busy_o     = busy;

    assign bus.iss_stall_o = bus.iss_valid_i && (
        (bus.iss_rs1_used_i && busy[bus.iss_rs1_i]) ||
        (bus.iss_rs2_used_i && busy[bus.iss_rs2_i]) ||
        busy[bus.iss_rd_i] ||
        (bus.iss_long_i && outstanding == MAX_OUT) ||
        starve >= SAT);
    assign accept_long = bus.iss_valid_i && !bus.iss_stall_o && bus.iss_long_i;

    // Idle cycles keep presenting the last written address/data
    assign bus.rf_wr_en_o   = bus.pwb_valid_i ? bus.pwb_addr_i != '0 : pop && head_addr != '0;
    assign bus.rf_wr_addr_o = bus.pwb_valid_i ? bus.pwb_addr_i : pop ? head_addr : last_addr;
    assign bus.rf_wr_data_o = bus.pwb_valid_i ? bus.pwb_data_i : pop ? head_data : last_data;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.llu_addr_i;
            fifo_data[wr_ptr] <= bus.llu_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            starve      <= '0;
            busy        <= '0;
            last_addr   <= '0;
            last_data   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count       <= count + CW'(push) - CW'(pop);
            outstanding <= outstanding + OW'(accept_long) - OW'(pop);
            starve      <= pop ? '0 : (!empty && bus.pwb_valid_i && starve != SAT) ? starve + SW'(1) : starve;
            // Set is applied after clear so it wins on a same-address collision
            busy <= ((busy & ~({31'b0, pop} << head_addr)) |
                     ({31'b0, accept_long && bus.iss_rd_i != '0} << bus.iss_rd_i)) & 32'hFFFF_FFFE;
            if (bus.pwb_valid_i || pop) begin
                last_addr <= bus.rf_wr_addr_o;
                last_data <= bus.rf_wr_data_o;
            end
        end
    end
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb_rf_wb_scheduler: directed table, corner sequences and random traffic against a queue-based model of the scheduler
module tb_rf_wb_scheduler;
    localparam int DEPTH = 2, MAXO = 4, SLIM = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    rf_wb_if bus ();
    rf_wb_scheduler #(.FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SLIM)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic iv; logic [4:0] rs1; logic u1; logic [4:0] rd; logic lg;
        logic pv; logic [4:0] pa; logic [31:0] pd;
        logic lv; logic [4:0] la; logic [31:0] ld;
        logic e_stall; logic e_en; logic [4:0] e_addr; logic [31:0] e_data; logic [31:0] e_busy;
    } vec_t;
    typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;

    vec_t        tbl [12];
    ent_t        mq [$];
    logic [4:0]  lpend [$];
    logic [31:0] mbusy;
    int          mstarve;
    logic [4:0]  mlast_a;
    logic [31:0] mlast_d;
    int          cmp = 0, errs = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %h expected %h", n, $time, act, exp);
        end
    endtask

    task automatic set_iss(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] rd, input logic lg);
        bus.iss_valid_i = v; bus.iss_rs1_i = r1; bus.iss_rs1_used_i = u1;
        bus.iss_rs2_i = 5'd0; bus.iss_rs2_used_i = 1'b0; bus.iss_rd_i = rd; bus.iss_long_i = lg;
    endtask

    task automatic set_pwb(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.pwb_valid_i = v; bus.pwb_addr_i = a; bus.pwb_data_i = d;
    endtask

    task automatic set_llu(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.llu_valid_i = v; bus.llu_addr_i = a; bus.llu_data_i = d;
    endtask

    task automatic model_clear();
        mq.delete(); lpend.delete();
        mbusy = '0; mstarve = 0; mlast_a = '0; mlast_d = '0;
    endtask

    // Outstanding ops are those still inside the LLU plus those waiting in the buffer
    task automatic cyc();
        int outst;
        logic e_stall, e_ready, pop, acc;
        ent_t h;
        #1;
        outst   = lpend.size() + mq.size();
        e_ready = mq.size() < DEPTH;
        e_stall = bus.iss_valid_i && ((bus.iss_rs1_used_i && mbusy[bus.iss_rs1_i]) ||
                  (bus.iss_rs2_used_i && mbusy[bus.iss_rs2_i]) || mbusy[bus.iss_rd_i] ||
                  (bus.iss_long_i && outst == MAXO) || mstarve >= SLIM);
        pop = !bus.pwb_valid_i && mq.size() > 0;
        if (bus.pwb_valid_i) h = '{bus.pwb_addr_i, bus.pwb_data_i};
        else if (pop) h = mq[0];
        else h = '{mlast_a, mlast_d};
        chk("stall", bus.iss_stall_o, e_stall);
        chk("ready", bus.llu_ready_o, e_ready);
        chk("wr_en", bus.rf_wr_en_o, (bus.pwb_valid_i || pop) && h.a != 5'd0);
        chk("wr_addr", bus.rf_wr_addr_o, h.a);
        chk("wr_data", bus.rf_wr_data_o, h.d);
        chk("busy", bus.busy_o, mbusy);
        @(posedge clk);
        #1;
        acc = bus.iss_valid_i && !e_stall && bus.iss_long_i;
        if (pop) begin
            mbusy[mq[0].a] = 1'b0;
            void'(mq.pop_front());
            mstarve = 0;
        end else if (bus.pwb_valid_i && mq.size() > 0 && mstarve < SLIM) mstarve++;
        if (bus.pwb_valid_i || pop) begin
            mlast_a = h.a;
            mlast_d = h.d;
        end
        if (bus.llu_valid_i && e_ready) begin
            mq.push_back('{bus.llu_addr_i, bus.llu_data_i});
            if (lpend.size() > 0) void'(lpend.pop_front());
        end
        if (acc) begin
            if (bus.iss_rd_i != 5'd0) mbusy[bus.iss_rd_i] = 1'b1;
            lpend.push_back(bus.iss_rd_i);
        end
    endtask

    task automatic do_reset();
        set_iss(0, 0, 0, 0, 0); set_pwb(0, 0, 0); set_llu(0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", bus.busy_o, 32'h0);
        chk("rst_ready", bus.llu_ready_o, 1);
        chk("rst_wr_en", bus.rf_wr_en_o, 0);
        chk("rst_wr_addr", bus.rf_wr_addr_o, 0);
        chk("rst_wr_data", bus.rf_wr_data_o, 0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1, 5, 1, 0, 0, 0, 0, 0,    0, 0, 0,            0, 0, 0, 0,            0};
        tbl[1]  = '{1, 0, 0, 7, 1, 0, 0, 0,    0, 0, 0,            0, 0, 0, 0,            0};
        tbl[2]  = '{1, 7, 1, 1, 0, 0, 0, 0,    0, 0, 0,            1, 0, 0, 0,            'h80};
        tbl[3]  = '{1, 7, 1, 1, 0, 0, 0, 0,    1, 7, 'hDEADBEEF,   1, 0, 0, 0,            'h80};
        tbl[4]  = '{1, 7, 1, 1, 0, 0, 0, 0,    0, 0, 0,            1, 1, 7, 'hDEADBEEF,   'h80};
        tbl[5]  = '{1, 7, 1, 1, 0, 0, 0, 0,    0, 0, 0,            0, 0, 7, 'hDEADBEEF,   0};
        tbl[6]  = '{1, 0, 0, 9, 1, 0, 0, 0,    0, 0, 0,            0, 0, 7, 'hDEADBEEF,   0};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0,    1, 9, 'h22,         0, 0, 7, 'hDEADBEEF,   'h200};
        tbl[8]  = '{0, 0, 0, 0, 0, 1, 3, 'h11, 0, 0, 0,            0, 1, 3, 'h11,         'h200};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0,            0, 1, 9, 'h22,         'h200};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0,            0, 0, 9, 'h22,         0};
        tbl[11] = '{0, 0, 0, 0, 0, 1, 0, 'h55, 0, 0, 0,            0, 0, 0, 'h55,         0};

        set_iss(0, 0, 0, 0, 0); set_pwb(0, 0, 0); set_llu(0, 0, 0);
        model_clear();
        #2;
        do_reset();

        for (int i = 0; i < 12; i++) begin
            set_iss(tbl[i].iv, tbl[i].rs1, tbl[i].u1, tbl[i].rd, tbl[i].lg);
            set_pwb(tbl[i].pv, tbl[i].pa, tbl[i].pd);
            set_llu(tbl[i].lv, tbl[i].la, tbl[i].ld);
            #1;
            chk($sformatf("tbl%0d_stall", i), bus.iss_stall_o, tbl[i].e_stall);
            chk($sformatf("tbl%0d_en", i), bus.rf_wr_en_o, tbl[i].e_en);
            chk($sformatf("tbl%0d_addr", i), bus.rf_wr_addr_o, tbl[i].e_addr);
            chk($sformatf("tbl%0d_data", i), bus.rf_wr_data_o, tbl[i].e_data);
            chk($sformatf("tbl%0d_busy", i), bus.busy_o, tbl[i].e_busy);
            cyc();
        end
        set_pwb(0, 0, 0);

        // Outstanding cap
        for (int i = 0; i < 4; i++) begin
            set_iss(1, 0, 0, 5'(10 + i), 1);
            cyc();
        end
        set_iss(1, 0, 0, 14, 1);
        #1 chk("cap_stall", bus.iss_stall_o, 1);
        cyc();
        set_iss(1, 1, 1, 15, 0);
        #1 chk("cap_short_op", bus.iss_stall_o, 0);
        cyc();
        set_iss(1, 0, 0, 14, 1);
        set_llu(1, 10, 32'hA);
        cyc();
        set_llu(0, 0, 0);
        cyc();
        #1 chk("cap_release", bus.iss_stall_o, 0);
        cyc();

        // Writeback starvation
        set_iss(1, 3, 1, 2, 0);
        set_pwb(1, 4, 32'h44);
        set_llu(1, 11, 32'hB);
        #1 chk("starve_start", bus.iss_stall_o, 0);
        cyc();
        set_llu(0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            #1 chk($sformatf("starve_c%0d", k), bus.iss_stall_o, k >= 9);
            cyc();
        end
        set_pwb(0, 0, 0);
        #1;
        chk("starve_pop_en", bus.rf_wr_en_o, 1);
        chk("starve_pop_addr", bus.rf_wr_addr_o, 11);
        chk("starve_hold", bus.iss_stall_o, 1);
        cyc();
        #1 chk("starve_clear", bus.iss_stall_o, 0);
        cyc();

        // Long op to x0, then drain everything
        set_iss(1, 0, 0, 0, 1);
        #1 chk("rd0_stall", bus.iss_stall_o, 0);
        cyc();
        set_iss(0, 0, 0, 0, 0);
        #1 chk("rd0_busy", bus.busy_o, 32'h0000_7000);
        for (int k = 0; k < 20 && lpend.size() > 0; k++) begin
            set_llu(1, lpend[0], $urandom);
            cyc();
        end
        set_llu(0, 0, 0);
        repeat (3) cyc();
        chk("drain_busy", bus.busy_o, 32'h0);

        // Reset with a full buffer
        set_iss(1, 0, 0, 20, 1);
        cyc();
        set_iss(1, 0, 0, 21, 1);
        cyc();
        set_iss(0, 0, 0, 0, 0);
        set_pwb(1, 4, 32'h1);
        set_llu(1, 20, 32'hA0);
        cyc();
        set_llu(1, 21, 32'hA1);
        cyc();
        set_llu(0, 0, 0);
        #1;
        chk("pre_rst_busy", bus.busy_o, 32'h0030_0000);
        chk("pre_rst_ready", bus.llu_ready_o, 0);
        do_reset();

        // Random traffic; periodic heavy writeback phases provoke starvation
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) begin
                do_reset();
                continue;
            end
            set_iss(1'($urandom % 4 != 0), 5'($urandom % 8), 1'($urandom % 2), 5'($urandom % 8), 1'($urandom % 3 == 0));
            bus.iss_rs2_i = 5'($urandom % 8);
            bus.iss_rs2_used_i = 1'($urandom % 2);
            set_pwb(((n / 100) % 3 == 2) ? 1'($urandom % 8 != 0) : 1'($urandom % 3 == 0), 5'($urandom % 32), $urandom);
            if (lpend.size() > 0 && $urandom % 2 == 1) set_llu(1, lpend[0], $urandom);
            else set_llu(0, 0, 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
